lc3_writeback: RTL and testbench

LC3_WRITEBACK -- requirements
Module: lc3_writeback

---
 rtl/writeback_pkg.sv | 34 +++
 rtl/lc3_regfile.sv | 41 ++++
 rtl/lc3_writeback.sv | 66 ++++++
 tb/tb_lc3_writeback.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared encodings and widths for the LC-3 writeback stage
//
// Purpose: write-data source encodings, condition-code constants, register
// file geometry and the condition-code derivation helper.
// Ports: none (package).
package writeback_pkg;

   localparam int REG_W = 16;
   localparam int REG_N = 8;
   localparam int REG_A = $clog2(REG_N);

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2,
      WB_NPC = 2'd3
   } wb_sel_e;

   localparam logic [2:0] PSR_N   = 3'b100;
   localparam logic [2:0] PSR_Z   = 3'b010;
   localparam logic [2:0] PSR_P   = 3'b001;
   localparam logic [2:0] PSR_RST = 3'b000;

   // Sign bit wins over the zero test, so 16'h8000 is negative, not zero.
   function automatic logic [2:0] psr_of(input logic [REG_W-1:0] value);
      if (value[REG_W-1])
         return PSR_N;
      else if (value == '0)
         return PSR_Z;
      else
         return PSR_P;
   endfunction

endpackage

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - 8 x 16-bit register file, one write port, two async read ports
//
// Purpose: general register array R0..R7.
// Ports:
//   clock       rising-edge clock
//   reset       async active-low reset, clears every register
//   we          write enable
//   waddr       write address
//   wdata       write data
//   raddr1/2    read addresses
//   rdata1/2    combinational read data (no write bypass)
module lc3_regfile
   import writeback_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [REG_A-1:0] waddr,
   input  logic [REG_W-1:0] wdata,
   input  logic [REG_A-1:0] raddr1,
   input  logic [REG_A-1:0] raddr2,
   output logic [REG_W-1:0] rdata1,
   output logic [REG_W-1:0] rdata2
);

   logic [REG_W-1:0] regs [REG_N];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_N; i++)
            regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads see the stored value only; a same-cycle write appears after the edge.
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// rtl/lc3_writeback.sv - LC-3 writeback stage: write-data select, register file, condition codes
//
// Purpose: selects the write-back value, writes it into the register file
// and updates the registered {N,Z,P} condition codes on enabled edges.
// Ports:
//   clock             rising-edge clock
//   reset             async active-low reset
//   enable_writeback  gates register write and psr update
//   W_Control         write-data source (ALU / memory / LEA address / next PC)
//   aluout, memout, pcout, npc   candidate write data
//   sr1, sr2          read addresses
//   dr                destination register
//   VSR1, VSR2        RF[sr1], RF[sr2]
//   psr               condition codes {N,Z,P}
module lc3_writeback
   import writeback_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_writeback,
   input  logic [1:0]       W_Control,
   input  logic [REG_W-1:0] aluout,
   input  logic [REG_W-1:0] memout,
   input  logic [REG_W-1:0] pcout,
   input  logic [REG_W-1:0] npc,
   input  logic [REG_A-1:0] sr1,
   input  logic [REG_A-1:0] sr2,
   input  logic [REG_A-1:0] dr,
   output logic [REG_W-1:0] VSR1,
   output logic [REG_W-1:0] VSR2,
   output logic [2:0]       psr
);

   logic [REG_W-1:0] dr_in;

   always_comb begin
      dr_in = aluout;
      case (wb_sel_e'(W_Control))
         WB_ALU:  dr_in = aluout;
         WB_MEM:  dr_in = memout;
         WB_PC:   dr_in = pcout;
         WB_NPC:  dr_in = npc;
         default: dr_in = aluout;
      endcase
   end

   lc3_regfile u_regfile (
      .clock  (clock),
      .reset  (reset),
      .we     (enable_writeback),
      .waddr  (dr),
      .wdata  (dr_in),
      .raddr1 (sr1),
      .raddr2 (sr2),
      .rdata1 (VSR1),
      .rdata2 (VSR2)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         psr <= PSR_RST;
      else if (enable_writeback)
         psr <= psr_of(dr_in);
   end

endmodule

// File: tb/tb_lc3_writeback.sv
// tb/tb_lc3_writeback.sv - directed self-checking bench for lc3_writeback
module tb_lc3_writeback;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_writeback;
   logic [1:0]  W_Control;
   logic [15:0] aluout, memout, pcout, npc;
   logic [2:0]  sr1, sr2, dr;
   logic [15:0] VSR1, VSR2;
   logic [2:0]  psr;

   int errors = 0;
   int checks = 0;

   lc3_writeback dut (
      .clock            (clock),
      .reset            (reset),
      .enable_writeback (enable_writeback),
      .W_Control        (W_Control),
      .aluout           (aluout),
      .memout           (memout),
      .pcout            (pcout),
      .npc              (npc),
      .sr1              (sr1),
      .sr2              (sr2),
      .dr               (dr),
      .VSR1             (VSR1),
      .VSR2             (VSR2),
      .psr              (psr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive an enabled write at the falling edge, let one rising edge take it,
   // then drop the enable just after the edge.
   task automatic do_write(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] m,
                           input logic [15:0] p, input logic [15:0] n, input logic [2:0] d);
      @(negedge clock);
      enable_writeback = 1'b1;
      W_Control = sel;
      aluout = a; memout = m; pcout = p; npc = n; dr = d;
      @(posedge clock);
      #1 enable_writeback = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      enable_writeback = 1'b0;
      W_Control = 2'd0;
      aluout = 16'h0; memout = 16'h0; pcout = 16'h0; npc = 16'h0;
      sr1 = 3'd0; sr2 = 3'd7; dr = 3'd0;

      // Reset state
      #2;
      check("rst_vsr1", VSR1, 16'h0000);
      check("rst_vsr2", VSR2, 16'h0000);
      check("rst_psr", {13'b0, psr}, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // ALU write of a negative value; read port shows old value during the write cycle
      @(negedge clock);
      enable_writeback = 1'b1; W_Control = 2'd0;
      aluout = 16'h8001; memout = 16'h1111; pcout = 16'h2222; npc = 16'h3333;
      dr = 3'd3; sr1 = 3'd3;
      #1 check("alu_pre_vsr1", VSR1, 16'h0000);
      @(posedge clock);
      #1 enable_writeback = 1'b0;
      check("alu_vsr1", VSR1, 16'h8001);
      check("alu_psr", {13'b0, psr}, 16'h0004);

      // Memory source, zero value; aluout left negative to catch a wrong select
      do_write(2'd1, 16'h8001, 16'h0000, 16'h2222, 16'h3333, 3'd5);
      sr1 = 3'd5; #1;
      check("mem_vsr1", VSR1, 16'h0000);
      check("mem_psr", {13'b0, psr}, 16'h0002);

      do_write(2'd2, 16'h8001, 16'hFFFF, 16'h3005, 16'h0000, 3'd6);
      sr1 = 3'd6; #1;
      check("pc_vsr1", VSR1, 16'h3005);
      check("pc_psr", {13'b0, psr}, 16'h0001);

      do_write(2'd3, 16'h0000, 16'h8000, 16'hFFFF, 16'h3010, 3'd7);
      sr2 = 3'd7; #1;
      check("npc_vsr2", VSR2, 16'h3010);
      check("npc_psr", {13'b0, psr}, 16'h0001);

      // Disabled write leaves RF and psr alone
      @(negedge clock);
      enable_writeback = 1'b0; W_Control = 2'd0; aluout = 16'hFFFF; dr = 3'd3;
      @(posedge clock);
      #1 sr1 = 3'd3; #1;
      check("dis_r3", VSR1, 16'h8001);
      check("dis_psr", {13'b0, psr}, 16'h0001);

      // Same-register read during write: old value, then new
      do_write(2'd0, 16'h5555, 16'h0, 16'h0, 16'h0, 3'd2);
      @(negedge clock);
      enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h1234; dr = 3'd2;
      sr1 = 3'd2; sr2 = 3'd2;
      #1;
      check("byp_old_vsr1", VSR1, 16'h5555);
      check("byp_old_vsr2", VSR2, 16'h5555);
      @(posedge clock);
      #1 enable_writeback = 1'b0;
      check("byp_new_vsr1", VSR1, 16'h1234);
      check("byp_new_vsr2", VSR2, 16'h1234);

      // Reset asserted in the middle of a write clears immediately and wins the edge
      do_write(2'd0, 16'h7777, 16'h0, 16'h0, 16'h0, 3'd1);
      sr1 = 3'd1; sr2 = 3'd6; #1;
      check("pre_rst_r1", VSR1, 16'h7777);
      @(negedge clock);
      enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h8000; dr = 3'd1;
      #2 reset = 1'b0;
      #1;
      check("async_rst_r1", VSR1, 16'h0000);
      check("async_rst_r6", VSR2, 16'h0000);
      check("async_rst_psr", {13'b0, psr}, 16'h0000);
      @(posedge clock);
      #1;
      check("rst_edge_r1", VSR1, 16'h0000);
      check("rst_edge_psr", {13'b0, psr}, 16'h0000);

      // First edge after reset release performs a write
      @(negedge clock);
      reset = 1'b1;
      enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h0042; dr = 3'd4; sr1 = 3'd4;
      @(posedge clock);
      #1 enable_writeback = 1'b0;
      check("post_rst_r4", VSR1, 16'h0042);
      check("post_rst_psr", {13'b0, psr}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
